mat_stream_ctrl: RTL and testbench

- Sequential front/back end for the 2x2 combinational matrix multiplier (mat_mult, 8-bit elements).
- Collects eight input bytes from a valid/ready byte stream and presents them as packed 32-bit A and B words to the multiplier.
- Captures the packed 32-bit result and streams it out as four bytes on a valid/ready byte stream.
- Sits directly upstream and downstream of the multiplier; the multiplier is instantiated alongside this block, not inside it.

---
 rtl/mat_pkg.sv | 25 ++
 rtl/mat_stream_ctrl_if.sv | 25 ++
 rtl/mat_stream_ctrl.sv | 125 ++++++++++++
 tb/tb_mat_stream_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the 2x2 matrix stream controller and its multiplier.
// Element slots are packed MSB-first: slot 0 (x00) sits in the top byte.
package mat_pkg;

    localparam int ELEM_W_DEF = 8;
    localparam int N          = 2;
    localparam int NELEM      = N * N;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int SLOT_00 = 0;
    localparam int SLOT_01 = 1;
    localparam int SLOT_10 = 2;
    localparam int SLOT_11 = 3;

    // LSB position of an element slot inside a packed word
    function automatic int slot_lsb(input int slot, input int elem_w);
        return (NELEM - 1 - slot) * elem_w;
    endfunction

endpackage

// File: rtl/mat_stream_ctrl_if.sv
// Byte-stream and multiplier-side signals of mat_stream_ctrl.
// master = the controller, slave = the environment (source, sink, multiplier).
interface mat_stream_ctrl_if #(
    parameter int ELEM_W = mat_pkg::ELEM_W_DEF
);
    logic [ELEM_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [ELEM_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic [4*ELEM_W-1:0] mm_a;
    logic [4*ELEM_W-1:0] mm_b;
    logic [4*ELEM_W-1:0] mm_res;

    modport master (
        input  in_data, in_valid, out_ready, mm_res,
        output in_ready, out_data, out_valid, mm_a, mm_b
    );

    modport slave (
        output in_data, in_valid, out_ready, mm_res,
        input  in_ready, out_data, out_valid, mm_a, mm_b
    );
endinterface

// File: rtl/mat_stream_ctrl.sv
// Streams eight input bytes into packed A/B words for an external 2x2 multiplier,
// captures its combinational result and streams it back out as four bytes.
module mat_stream_ctrl
    import mat_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    mat_stream_ctrl_if.master bus,
    output logic          busy,
    output logic          done
);

    localparam int WORD_W = NELEM * ELEM_W;

    state_e              state_q, state_d;
    logic [2:0]          in_cnt_q, in_cnt_d;
    logic [1:0]          out_cnt_q, out_cnt_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic [WORD_W-1:0]   res_q, res_d;
    logic                done_q, done_d;
    logic                in_xfer, out_xfer;
    logic [ELEM_W-1:0]   out_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        done_d    = 1'b0;
        in_xfer   = (state_q == LOAD) && bus.in_valid;
        out_xfer  = (state_q == SEND) && bus.out_ready;

        // clr wins over any transfer on the same edge
        if (clr) begin
            state_d   = LOAD;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            a_d       = '0;
            b_d       = '0;
            res_d     = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_xfer) begin
                        for (int k = 0; k < NELEM; k++) begin
                            if (in_cnt_q[1:0] == 2'(k)) begin
                                if (in_cnt_q[2])
                                    b_d[slot_lsb(k, ELEM_W) +: ELEM_W] = bus.in_data;
                                else
                                    a_d[slot_lsb(k, ELEM_W) +: ELEM_W] = bus.in_data;
                            end
                        end
                        if (in_cnt_q == 3'd7) begin
                            in_cnt_d = '0;
                            state_d  = CALC;
                        end else begin
                            in_cnt_d = in_cnt_q + 3'd1;
                        end
                    end
                end
                CALC: begin
                    res_d     = bus.mm_res;
                    out_cnt_d = '0;
                    state_d   = SEND;
                end
                SEND: begin
                    if (out_xfer) begin
                        if (out_cnt_q == 2'd3) begin
                            out_cnt_d = '0;
                            done_d    = 1'b1;
                            state_d   = LOAD;
                        end else begin
                            out_cnt_d = out_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Output byte is a pure mux of registers, so it holds while stalled
    always_comb begin
        out_sel = '0;
        for (int k = 0; k < NELEM; k++) begin
            if (out_cnt_q == 2'(k))
                out_sel = res_q[slot_lsb(k, ELEM_W) +: ELEM_W];
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = out_sel;
    assign bus.mm_a      = a_q;
    assign bus.mm_b      = b_q;
    assign busy          = (state_q == CALC) || (state_q == SEND);
    assign done          = done_q;

endmodule

// File: tb/tb_mat_stream_ctrl.sv
// Directed and randomized jobs for mat_stream_ctrl with a behavioural 2x2
// multiplier on mm_res and a matrix-level reference model for the result bytes.
module tb_mat_stream_ctrl;
    import mat_pkg::*;

    typedef logic [7:0] job_t [8];
    typedef logic [7:0] res_t [4];

    logic clk = 1'b0;
    logic rst_n, clr, busy, done;
    int   checks = 0;
    int   failures = 0;

    mat_stream_ctrl_if #(.ELEM_W(8)) bus ();

    mat_stream_ctrl #(.ELEM_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Stand-in for mat_mult: 8-bit wrapping 2x2 product
    function automatic logic [31:0] mul2x2(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            ea[k] = a[31-8*k -: 8];
            eb[k] = b[31-8*k -: 8];
        end
        r[31:24] = ea[0] * eb[0] + ea[1] * eb[2];
        r[23:16] = ea[0] * eb[1] + ea[1] * eb[3];
        r[15:8]  = ea[2] * eb[0] + ea[3] * eb[2];
        r[7:0]   = ea[2] * eb[1] + ea[3] * eb[3];
        return r;
    endfunction

    assign bus.mm_res = mul2x2(bus.mm_a, bus.mm_b);

    // Reference: row-major matrices from the byte order, results mod 256
    function automatic void ref_model(input job_t b, output res_t r);
        int am [2][2];
        int bm [2][2];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                am[i][j] = int'(b[2*i+j]);
                bm[i][j] = int'(b[4+2*i+j]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                r[2*i+j] = 8'((am[i][0] * bm[0][j] + am[i][1] * bm[1][j]) % 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts and ends just after a falling edge.
    // or_mode: 0 out_ready=1, 1 toggle, 2 random. abort_mode: 0 none, 1 clr, 2 async reset.
    task automatic run_job(input job_t bytes, input bit rnd_in, input int or_mode,
                           input int abort_mode, input int abort_at);
        res_t       exp;
        int         idx = 0, oidx = 0, cyc = 0, c_last_in = -100;
        bit         stalled = 1'b0, exp_ov, in_x, out_x;
        logic [7:0] held = '0;
        ref_model(bytes, exp);
        while (1) begin
            if (cyc > 400) begin
                checks++;
                failures++;
                $error("FAIL job_timeout got=cyc%0d exp=done", cyc);
                return;
            end
            exp_ov = (idx == 8) && (cyc >= c_last_in + 2) && (oidx < 4);
            if (cyc > 0) chk("done_idle", {31'd0, done}, 32'd0);
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, idx < 8});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
            if (stalled && exp_ov) chk("out_hold", {24'd0, bus.out_data}, {24'd0, held});

            if (abort_mode != 0 && exp_ov && oidx == abort_at) begin
                if (abort_mode == 1) begin
                    clr = 1'b1;
                    bus.out_ready = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    clr = 1'b0;
                    bus.in_valid = 1'b0;
                    chk("clr_ov", {31'd0, bus.out_valid}, 32'd0);
                    chk("clr_done", {31'd0, done}, 32'd0);
                    chk("clr_busy", {31'd0, busy}, 32'd0);
                    chk("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
                    chk("clr_out_data", {24'd0, bus.out_data}, 32'd0);
                    chk("clr_mm_a", bus.mm_a, 32'd0);
                    @(posedge clk);
                    @(negedge clk);
                    chk("clr_done_late", {31'd0, done}, 32'd0);
                end else begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk("arst_ov", {31'd0, bus.out_valid}, 32'd0);
                    chk("arst_busy", {31'd0, busy}, 32'd0);
                    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
                    chk("arst_done", {31'd0, done}, 32'd0);
                    chk("arst_out_data", {24'd0, bus.out_data}, 32'd0);
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                return;
            end

            if (idx < 8) begin
                bus.in_valid = rnd_in ? 1'($urandom_range(1)) : 1'b1;
                bus.in_data  = bytes[idx];
            end else begin
                bus.in_valid = 1'($urandom_range(1));
                bus.in_data  = 8'($urandom);
            end
            case (or_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = cyc[0];
                default: bus.out_ready = 1'($urandom_range(1));
            endcase
            in_x  = bus.in_valid && (idx < 8);
            out_x = bus.out_ready && exp_ov;
            if (out_x) begin
                chk($sformatf("out_byte%0d", oidx), {24'd0, bus.out_data}, {24'd0, exp[oidx]});
                oidx++;
            end
            stalled = exp_ov && !bus.out_ready;
            held    = bus.out_data;
            if (in_x) begin
                idx++;
                if (idx == 8) c_last_in = cyc;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (oidx == 4) begin
                bus.in_valid = 1'b0;
                chk("done_pulse", {31'd0, done}, 32'd1);
                chk("done_in_ready", {31'd0, bus.in_ready}, 32'd1);
                chk("done_ov", {31'd0, bus.out_valid}, 32'd0);
                chk("done_busy", {31'd0, busy}, 32'd0);
                chk("keep_mm_a", bus.mm_a, {bytes[0], bytes[1], bytes[2], bytes[3]});
                chk("keep_mm_b", bus.mm_b, {bytes[4], bytes[5], bytes[6], bytes[7]});
                return;
            end
        end
    endtask

    initial begin
        job_t j_basic, j_ovf, j_max, j_id, j_rnd;
        j_basic = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        j_ovf   = '{8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16};
        j_max   = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255};
        j_id    = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};

        rst_n = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_mm_a", bus.mm_a, 32'd0);
        chk("rst_mm_b", bus.mm_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(j_basic, 1'b0, 0, 0, 0);
        run_job(j_ovf, 1'b0, 0, 0, 0);
        run_job(j_max, 1'b0, 0, 0, 0);
        run_job(j_basic, 1'b1, 1, 0, 0);
        run_job(j_basic, 1'b0, 0, 0, 0);
        run_job(j_id, 1'b0, 0, 0, 0);

        // abort mid-LOAD after five bytes; the byte offered with clr is dropped
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = j_id[k];
            @(posedge clk);
            @(negedge clk);
        end
        clr = 1'b1;
        bus.in_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("load_clr_mm_a", bus.mm_a, 32'd0);
        chk("load_clr_mm_b", bus.mm_b, 32'd0);
        chk("load_clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        run_job(j_basic, 1'b0, 0, 0, 0);

        run_job(j_basic, 1'b0, 0, 1, 2);
        run_job(j_id, 1'b1, 2, 0, 0);

        run_job(j_basic, 1'b0, 0, 2, 1);
        run_job(j_basic, 1'b1, 2, 0, 0);

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 8; k++) j_rnd[k] = 8'($urandom);
            run_job(j_rnd, 1'($urandom_range(1)), int'($urandom_range(2)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
